// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one combinational ALU between two requesters.
// Define ALU_ARB_STATS_EN to add saturating per-requester grant counters with a clear input.
module alu_arbiter #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned EXEC_CYCLES = 1
`ifdef ALU_ARB_STATS_EN
    ,
    parameter int unsigned CNT_W       = 16
`endif
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              REQ0_VALID,
    output logic              REQ0_READY,
    input  logic [2:0]        REQ0_SELECT,
    input  logic [DATA_W-1:0] REQ0_DATA1,
    input  logic [DATA_W-1:0] REQ0_DATA2,
    input  logic              REQ1_VALID,
    output logic              REQ1_READY,
    input  logic [2:0]        REQ1_SELECT,
    input  logic [DATA_W-1:0] REQ1_DATA1,
    input  logic [DATA_W-1:0] REQ1_DATA2,
    output logic [DATA_W-1:0] ALU_DATA1,
    output logic [DATA_W-1:0] ALU_DATA2,
    output logic [2:0]        ALU_SELECT,
    input  logic [DATA_W-1:0] ALU_RESULT,
    output logic              RESP_VALID,
    input  logic              RESP_READY,
    output logic              RESP_ID,
    output logic [DATA_W-1:0] RESP_RESULT,
    output logic              RESP_ERR
`ifdef ALU_ARB_STATS_EN
    ,
    input  logic              STATS_CLR,
    output logic [CNT_W-1:0]  GRANT_CNT0,
    output logic [CNT_W-1:0]  GRANT_CNT1
`endif
);

    localparam int unsigned CW = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(EXEC_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t              r_state;
    logic                r_prio;
    logic [CW-1:0]       r_cnt;
    logic [DATA_W-1:0]   r_alu_d1;
    logic [DATA_W-1:0]   r_alu_d2;
    logic [2:0]          r_alu_sel;
    logic                r_resp_valid;
    logic                r_resp_id;
    logic [DATA_W-1:0]   r_resp_result;
    logic                r_resp_err;

    logic                w_idle;
    logic                w_grant0;
    logic                w_grant1;
    logic                w_hs;
    logic [2:0]          w_sel;
    logic [DATA_W-1:0]   w_d1;
    logic [DATA_W-1:0]   w_d2;

    // PRIO only breaks ties; a lone valid requester always wins.
    assign w_idle   = (r_state == IDLE);
    assign w_grant0 = w_idle && REQ0_VALID && (!REQ1_VALID || !r_prio);
    assign w_grant1 = w_idle && REQ1_VALID && (!REQ0_VALID ||  r_prio);
    assign w_hs     = w_grant0 || w_grant1;
    assign w_sel    = w_grant1 ? REQ1_SELECT : REQ0_SELECT;
    assign w_d1     = w_grant1 ? REQ1_DATA1  : REQ0_DATA1;
    assign w_d2     = w_grant1 ? REQ1_DATA2  : REQ0_DATA2;

    assign REQ0_READY  = w_grant0;
    assign REQ1_READY  = w_grant1;
    assign ALU_DATA1   = r_alu_d1;
    assign ALU_DATA2   = r_alu_d2;
    assign ALU_SELECT  = r_alu_sel;
    assign RESP_VALID  = r_resp_valid;
    assign RESP_ID     = r_resp_id;
    assign RESP_RESULT = r_resp_result;
    assign RESP_ERR    = r_resp_err;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state       <= IDLE;
            r_prio        <= 1'b0;
            r_cnt         <= '0;
            r_alu_d1      <= '0;
            r_alu_d2      <= '0;
            r_alu_sel     <= '0;
            r_resp_valid  <= 1'b0;
            r_resp_id     <= 1'b0;
            r_resp_result <= '0;
            r_resp_err    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_hs) begin
                        r_alu_d1  <= w_d1;
                        r_alu_d2  <= w_d2;
                        r_alu_sel <= w_sel;
                        r_resp_id <= w_grant1;
                        r_prio    <= ~w_grant1;
                        // Unsupported opcodes skip the ALU and answer immediately.
                        if (w_sel[2]) begin
                            r_resp_result <= '0;
                            r_resp_err    <= 1'b1;
                            r_resp_valid  <= 1'b1;
                            r_state       <= RESP;
                        end else begin
                            r_cnt   <= CNT_LOAD;
                            r_state <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    if (r_cnt == '0) begin
                        r_resp_result <= ALU_RESULT;
                        r_resp_err    <= 1'b0;
                        r_resp_valid  <= 1'b1;
                        r_state       <= RESP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (RESP_READY) begin
                        r_resp_valid <= 1'b0;
                        r_state      <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef ALU_ARB_STATS_EN
    logic [CNT_W-1:0] r_gcnt0;
    logic [CNT_W-1:0] r_gcnt1;

    assign GRANT_CNT0 = r_gcnt0;
    assign GRANT_CNT1 = r_gcnt1;

    // Clear wins over a same-cycle grant; counts saturate at all-ones.
    always_ff @(posedge CLK) begin
        if (RESET || STATS_CLR) begin
            r_gcnt0 <= '0;
            r_gcnt1 <= '0;
        end else begin
            if (w_grant0 && (r_gcnt0 != '1)) r_gcnt0 <= r_gcnt0 + 1'b1;
            if (w_grant1 && (r_gcnt1 != '1)) r_gcnt1 <= r_gcnt1 + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: vector table plus response scoreboard,
// with hand-written contention, backpressure and reset-abort sequences.
module tb_alu_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, v0, v1, r0, r1, rv, rr, rid, rerr;
    logic [2:0] s0, s1, alu_sel;
    logic [7:0] a0, b0, a1, b1, alu_d1, alu_d2, alu_res, rres;

    logic       rst3, d3_v, d3_r0, d3_r1, d3_rv, d3_rid, d3_rerr;
    logic [2:0] d3_s, d3_asel;
    logic [7:0] d3_a, d3_b, d3_ad1, d3_ad2, d3_ares, d3_rres;

`ifdef ALU_ARB_STATS_EN
    logic        sclr, sclr3;
    logic [15:0] gc0, gc1, gc0_3, gc1_3;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic       id;
        logic [2:0] sel;
        logic [7:0] d1;
        logic [7:0] d2;
        logic [7:0] res;
        logic       err;
    } vec_t;

    typedef struct packed {
        logic       id;
        logic [7:0] res;
        logic       err;
    } exp_t;

    exp_t sb[$];

    // Reference ALU: 00 forward DATA2, 01 add, 10 and, 11 or.
    function automatic logic [7:0] alu_f(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b);
        case (s[1:0])
            2'd0:    return b;
            2'd1:    return a + b;
            2'd2:    return a & b;
            default: return a | b;
        endcase
    endfunction

    assign alu_res = alu_f(alu_sel, alu_d1, alu_d2);
    assign d3_ares = alu_f(d3_asel, d3_ad1, d3_ad2);

    alu_arbiter #(.DATA_W(8), .EXEC_CYCLES(1)) u_dut (
        .CLK(clk), .RESET(rst),
        .REQ0_VALID(v0), .REQ0_READY(r0), .REQ0_SELECT(s0), .REQ0_DATA1(a0), .REQ0_DATA2(b0),
        .REQ1_VALID(v1), .REQ1_READY(r1), .REQ1_SELECT(s1), .REQ1_DATA1(a1), .REQ1_DATA2(b1),
        .ALU_DATA1(alu_d1), .ALU_DATA2(alu_d2), .ALU_SELECT(alu_sel), .ALU_RESULT(alu_res),
        .RESP_VALID(rv), .RESP_READY(rr), .RESP_ID(rid), .RESP_RESULT(rres), .RESP_ERR(rerr)
`ifdef ALU_ARB_STATS_EN
        , .STATS_CLR(sclr), .GRANT_CNT0(gc0), .GRANT_CNT1(gc1)
`endif
    );

    alu_arbiter #(.DATA_W(8), .EXEC_CYCLES(3)) u_dut3 (
        .CLK(clk), .RESET(rst3),
        .REQ0_VALID(d3_v), .REQ0_READY(d3_r0), .REQ0_SELECT(d3_s), .REQ0_DATA1(d3_a), .REQ0_DATA2(d3_b),
        .REQ1_VALID(1'b0), .REQ1_READY(d3_r1), .REQ1_SELECT(3'b000), .REQ1_DATA1(8'h00), .REQ1_DATA2(8'h00),
        .ALU_DATA1(d3_ad1), .ALU_DATA2(d3_ad2), .ALU_SELECT(d3_asel), .ALU_RESULT(d3_ares),
        .RESP_VALID(d3_rv), .RESP_READY(1'b1), .RESP_ID(d3_rid), .RESP_RESULT(d3_rres), .RESP_ERR(d3_rerr)
`ifdef ALU_ARB_STATS_EN
        , .STATS_CLR(sclr3), .GRANT_CNT0(gc0_3), .GRANT_CNT1(gc1_3)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic id, input logic [7:0] res, input logic err);
        exp_t e;
        e.id = id; e.res = res; e.err = err;
        sb.push_back(e);
    endtask

    // Response scoreboard and one-hot READY check on the main DUT.
    always @(negedge clk) begin
        if (!rst) begin
            if (r0 && r1) chk("two_ready", {r0, r1}, 2'b00);
            if (rv && rr) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_resp", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("resp_fields", {rid, rres, rerr}, {e.id, e.res, e.err});
                end
            end
        end
    end

    task automatic set_req(input logic id, input logic v, input logic [2:0] s, input logic [7:0] a, input logic [7:0] b);
        if (id) begin v1 = v; s1 = s; a1 = a; b1 = b; end
        else    begin v0 = v; s0 = s; a0 = a; b0 = b; end
    endtask

    task automatic do_op(input vec_t v, input string tag);
        int  lat;
        bit  got;
        @(posedge clk); #1;
        set_req(v.id, 1'b1, v.sel, v.d1, v.d2);
        push_exp(v.id, v.res, v.err);
        got = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (v.id ? r1 : r0) begin got = 1; break; end
        end
        chk({tag, "_ready"}, got, 1);
        if (!got) begin
            set_req(v.id, 1'b0, 3'b000, 8'h00, 8'h00);
            return;
        end
        @(posedge clk); #1;
        set_req(v.id, 1'b0, 3'b000, 8'h00, 8'h00);
        lat = 0; got = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rv) begin got = 1; break; end
            lat++;
        end
        chk({tag, "_latency"}, got ? lat : 99, v.err ? 0 : 1);
    endtask

    vec_t tbl[9];
    int   order[$];

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, %0d checks so far", n_chk);
        $fatal(1);
    end

    initial begin
        int  n0, n1, lat;
        bit  got, seen;
        logic [9:0] snap;

        tbl[0] = '{1'b0, 3'b001, 8'h0A, 8'h02, 8'h0C, 1'b0};
        tbl[1] = '{1'b0, 3'b001, 8'hF6, 8'h0A, 8'h00, 1'b0};
        tbl[2] = '{1'b0, 3'b010, 8'hF0, 8'h3C, 8'h30, 1'b0};
        tbl[3] = '{1'b1, 3'b011, 8'hF0, 8'h0F, 8'hFF, 1'b0};
        tbl[4] = '{1'b1, 3'b000, 8'h55, 8'h55, 8'h55, 1'b0};
        tbl[5] = '{1'b1, 3'b101, 8'h12, 8'h34, 8'h00, 1'b1};
        tbl[6] = '{1'b0, 3'b111, 8'hFF, 8'hFF, 8'h00, 1'b1};
        tbl[7] = '{1'b1, 3'b001, 8'h80, 8'h80, 8'h00, 1'b0};
        tbl[8] = '{1'b0, 3'b001, 8'h7F, 8'h01, 8'h80, 1'b0};

        rst = 1; rst3 = 1; rr = 1;
        set_req(1'b0, 1'b0, 3'b000, 8'h00, 8'h00);
        set_req(1'b1, 1'b0, 3'b000, 8'h00, 8'h00);
        d3_v = 0; d3_s = 0; d3_a = 0; d3_b = 0;
`ifdef ALU_ARB_STATS_EN
        sclr = 0; sclr3 = 0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_state", {rv, rid, rres, rerr, alu_d1, alu_d2, alu_sel, r0, r1}, 32'h0);
        chk("reset_state3", {d3_rv, d3_rid, d3_rres, d3_rerr, d3_ad1, d3_ad2, d3_asel, d3_r0, d3_r1}, 32'h0);
        @(posedge clk); #1;
        rst = 0; rst3 = 0;

        for (int i = 0; i < 9; i++) do_op(tbl[i], $sformatf("vec%0d", i));

        // Contention: both requesters valid straight out of reset.
        @(posedge clk); #1 rst = 1;
        @(posedge clk); #1 rst = 0;
        for (int k = 0; k < 4; k++) begin
            push_exp(1'b0, 8'(k * 3 + 17), 1'b0);
            push_exp(1'b1, 8'(8'hFF - k) & 8'h0F, 1'b0);
        end
        n0 = 0; n1 = 0;
        set_req(1'b0, 1'b1, 3'b001, 8'h00, 8'h11);
        set_req(1'b1, 1'b1, 3'b010, 8'hFF, 8'h0F);
        for (int cyc = 0; cyc < 200; cyc++) begin
            bit g0, g1;
            @(negedge clk);
            g0 = r0; g1 = r1;
            if (g0) order.push_back(0);
            if (g1) order.push_back(1);
            if (g0 || g1) begin
                @(posedge clk); #1;
                if (g0) begin
                    n0++;
                    if (n0 < 4) a0 = 8'(n0 * 3); else v0 = 0;
                end
                if (g1) begin
                    n1++;
                    if (n1 < 4) a1 = 8'(8'hFF - n1); else v1 = 0;
                end
            end
            if (n0 == 4 && n1 == 4) break;
        end
        for (int i = 0; i < 8; i++)
            chk($sformatf("grant_order%0d", i), (order.size() > i) ? order[i] : 9, i % 2);
        repeat (4) @(negedge clk);
        chk("contention_drain", sb.size(), 0);

        // Backpressure: hold RESP_READY low while requester 0 waits with a new op.
        @(posedge clk); #1 rr = 0;
        set_req(1'b0, 1'b1, 3'b001, 8'h01, 8'h02);
        push_exp(1'b0, 8'h03, 1'b0);
        got = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (r0) begin got = 1; break; end
        end
        chk("bp_first_ready", got, 1);
        @(posedge clk); #1;
        set_req(1'b0, 1'b1, 3'b011, 8'h30, 8'h03);
        push_exp(1'b0, 8'h33, 1'b0);
        got = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rv) begin got = 1; break; end
        end
        chk("bp_resp_valid", got, 1);
        snap = {rid, rres, rerr};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold", {rv, rid, rres, rerr}, {1'b1, snap});
            chk("bp_no_ready", {r0, r1}, 2'b00);
        end
        @(posedge clk); #1 rr = 1;
        @(negedge clk);
        chk("bp_ready_still_low", r0, 1'b0);
        @(negedge clk);
        chk("bp_ready_rise", r0, 1'b1);
        @(posedge clk); #1 v0 = 0;
        repeat (4) @(negedge clk);
        chk("bp_drain", sb.size(), 0);

        // EXEC_CYCLES=3 latency, then a reset in EXEC that must abandon the op.
        @(posedge clk); #1;
        d3_v = 1; d3_s = 3'b001; d3_a = 8'h05; d3_b = 8'h06;
        got = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (d3_r0) begin got = 1; break; end
        end
        @(posedge clk); #1 d3_v = 0;
        lat = 0; got = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (d3_rv) begin got = 1; break; end
            lat++;
        end
        chk("d3_latency", got ? lat : 99, 3);
        chk("d3_resp", {d3_rid, d3_rres, d3_rerr}, {1'b0, 8'h0B, 1'b0});
        @(posedge clk); #1;
        d3_v = 1; d3_s = 3'b001; d3_a = 8'h01; d3_b = 8'h01;
        got = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (d3_r0) begin got = 1; break; end
        end
        chk("d3_second_ready", got, 1);
        @(posedge clk); #1 d3_v = 0;
        @(posedge clk); #1 rst3 = 1;
        @(posedge clk); #1 rst3 = 0;
        @(negedge clk);
        chk("d3_abort_reset", {d3_rv, d3_rid, d3_rres, d3_rerr, d3_ad1, d3_ad2, d3_asel, d3_r0, d3_r1}, 32'h0);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (d3_rv) seen = 1;
        end
        chk("d3_no_resp_after_abort", seen, 0);

`ifdef ALU_ARB_STATS_EN
        @(posedge clk); #1 sclr = 1;
        @(posedge clk); #1 sclr = 0;
        do_op(tbl[0], "st0");
        do_op(tbl[3], "st1");
        do_op(tbl[2], "st2");
        do_op(tbl[4], "st3");
        do_op(tbl[8], "st4");
        @(negedge clk);
        chk("grant_cnt0", gc0, 3);
        chk("grant_cnt1", gc1, 2);
        @(posedge clk); #1 sclr = 1;
        @(posedge clk); #1 sclr = 0;
        @(negedge clk);
        chk("grant_cnt_clr", {gc0, gc1}, 32'h0);
`endif

        repeat (3) @(negedge clk);
        chk("sb_drain", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational 8-bit ALU (ops: forward, add, and, or) between two requesters.
- Grants one request at a time using round-robin priority, then drives the ALU operands and SELECT.
- Waits a fixed settle time, captures the ALU output, and returns it on a shared response channel tagged with the requester ID.
- Sits between the CPU datapath/auxiliary unit requesters and the single alu instance.

Parameters:
- DATA_W, 8, operand/result width.
- EXEC_CYCLES, 1, cycles operands are held on the ALU before the result is captured; must be >= 1.
- CNT_W, 16, width of the grant counters (optional feature only).

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- REQ0_VALID  input  1  requester 0 has an operation pending.
- REQ0_READY  output  1  requester 0 accepted this cycle.
- REQ0_SELECT  input  3  requester 0 ALU opcode.
- REQ0_DATA1  input  DATA_W  requester 0 operand 1.
- REQ0_DATA2  input  DATA_W  requester 0 operand 2.
- REQ1_VALID, REQ1_READY, REQ1_SELECT, REQ1_DATA1, REQ1_DATA2: same as requester 0, for requester 1.
- ALU_DATA1  output  DATA_W  to alu DATA1.
- ALU_DATA2  output  DATA_W  to alu DATA2.
- ALU_SELECT  output  3  to alu SELECT.
- ALU_RESULT  input  DATA_W  from alu RESULT.
- RESP_VALID  output  1  response available.
- RESP_READY  input  1  consumer accepts response.
- RESP_ID  output  1  requester that owns the response.
- RESP_RESULT  output  DATA_W  captured result.
- RESP_ERR  output  1  opcode was unsupported (3'b1xx).

Behaviour:
- Clock and reset: one clock, CLK; reset RESET is synchronous and active-high.
- Reset values: state IDLE; RESP_VALID, RESP_ID, RESP_RESULT, RESP_ERR, ALU_DATA1, ALU_DATA2, ALU_SELECT all 0; priority pointer PRIO=0; REQx_READY=0.
- Reset mid-operation abandons the transaction; no response is ever produced for it.
- States: IDLE, EXEC, RESP.
- REQx_READY:
  - Combinational, asserted only in IDLE, at most one high.
  - If only one VALID is high, that requester gets READY.
  - If both VALIDs are high, requester PRIO gets READY.
  - Requesters hold VALID and payload stable until READY.
- Handshake: occurs at the edge where REQx_VALID & REQx_READY.
  - ALU_DATA1, ALU_DATA2 and ALU_SELECT are registered from the winner.
  - RESP_ID is set to the winner.
  - PRIO is set to the non-winner.
  - Valid opcode (3'b0xx): go to EXEC, load counter with EXEC_CYCLES-1.
  - Invalid opcode (3'b1xx): go directly to RESP with RESP_RESULT=0, RESP_ERR=1, RESP_VALID=1. ALU_* registers still load, but their value is irrelevant.
- EXEC:
  - Counter decrements each cycle.
  - At the edge where counter==0: RESP_RESULT<=ALU_RESULT, RESP_ERR<=0, RESP_VALID<=1, go to RESP.
  - RESP_VALID is therefore high EXEC_CYCLES cycles after the handshake edge.
- ALU_DATA1, ALU_DATA2 and ALU_SELECT stay constant through EXEC and RESP.
- RESP:
  - RESP_VALID, RESP_ID, RESP_RESULT and RESP_ERR are held stable until RESP_READY=1 at an edge.
  - On that edge RESP_VALID<=0 and the state returns to IDLE.
  - RESP_READY is ignored outside RESP.
- No overlap: the next READY can assert no earlier than the cycle after response completion. Minimum op period is EXEC_CYCLES+2 cycles.
- Arithmetic is done entirely in the ALU. Add wraps modulo 2^DATA_W; no carry is reported.
- Fairness: with both requesters continuously valid, grants strictly alternate 0,1,0,1...

Optional Feature:
- Macro: ALU_ARB_STATS_EN.
- Defined:
  - Adds outputs GRANT_CNT0 and GRANT_CNT1 (CNT_W each) and input STATS_CLR (1).
  - A counter increments on each handshake of its requester and saturates at all-ones.
  - RESET or STATS_CLR clears both counters to 0. STATS_CLR takes priority over an increment in the same cycle.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Add, requester 0 only, SELECT=3'b001, DATA1=0x0A, DATA2=0x02, EXEC_CYCLES=1, RESP_READY=1 -> RESP_VALID one cycle after handshake, RESP_RESULT=0x0C, RESP_ID=0, RESP_ERR=0.
- Add wrap-around and opcode sweep: 0xF6+0x0A -> 0x00; then and 0xF0&0x3C -> 0x30, or 0xF0|0x0F -> 0xFF, forward (DATA2=0x55) -> 0x55.
- Contention: both requesters valid from reset, 4 ops each -> grant order 0,1,0,1,0,1,0,1; every RESP_ID matches; never two READYs in one cycle.
- Invalid opcode: requester 1 SELECT=3'b101 -> RESP_VALID on the cycle after handshake, RESP_RESULT=0x00, RESP_ERR=1, no EXEC state.
- Backpressure: RESP_READY low for 5 cycles after RESP_VALID -> response fields unchanged, REQx_READY stays 0 while REQ0_VALID=1; RESP_READY high -> REQ0_READY rises on the next cycle.
- Reset mid-op: EXEC_CYCLES=3, assert RESET during EXEC -> next cycle all outputs at reset values, no response for the aborted op. With ALU_ARB_STATS_EN defined: after 3 grants to requester 0 and 2 to requester 1, GRANT_CNT0=3 and GRANT_CNT1=2; STATS_CLR -> both 0.
